// File: rtl/sram_seq_pkg.sv
// Shared definitions for the SRAM port sequencer.
// Holds the command opcodes, the sequencer state encoding and the default
// timing parameters (external counter half-period and SRAM access length).
package sram_seq_pkg;

  // 50 cycles per counter phase gives a 1 MHz external counter clock at 100 MHz.
  localparam int DIV_DEFAULT      = 50;
  localparam int WAIT_CYC_DEFAULT = 2;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_CRST  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACCESS,
    S_ADV_HI,
    S_ADV_LO,
    S_CRST_HI,
    S_CRST_LO,
    S_DONE
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// A state lasting N cycles loads N-1 on entry; tc is high while the count
// is zero, i.e. during the last cycle of the state.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, count returns to RST_VAL
//   load     load load_val on the next rising edge
//   load_val value to load
//   tc       terminal count (count == 0)
module sram_phase_timer #(
  parameter int W       = 6,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sram_port_sequencer.sv
// Command-driven sequencer for a 16-bit SRAM (two byte-wide chips) whose
// address comes from an external MC14040B ripple counter. ADDR shadows that
// counter: it clears with COUNTER_RST and increments after each COUNTER_CLK
// pulse (the counter advances on the falling edge).
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   CMD_VALID/READY/OP     command handshake, opcode (write/read/crst/nop)
//   CMD_WDATA              write word (hi byte chip 2, lo byte chip 1)
//   RSP_VALID, RSP_RDATA   one-cycle completion pulse, last word read
//   ADDR                   shadow of external counter value
//   COUNTER_CLK/RST        external counter controls
//   WE_BAR                 SRAM write enable (active-low)
//   DATA_OE, DATA_OUT      bus tristate enable and drive value
//   DATA_IN                bus sample value
module sram_port_sequencer
  import sram_seq_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int WAIT_CYC = WAIT_CYC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [15:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic [11:0] ADDR,
  output logic        COUNTER_CLK,
  output logic        COUNTER_RST,
  output logic        WE_BAR,
  output logic        DATA_OE,
  output logic [15:0] DATA_OUT,
  input  logic [15:0] DATA_IN
);

  localparam int TW = $clog2(max2(DIV, WAIT_CYC) + 1);
  localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
  localparam logic [TW-1:0] WAIT_M1 = TW'(WAIT_CYC - 1);

  state_e        state, state_nxt;
  op_e           op;
  logic          init_lo, init_lo_set;
  logic          tmr_load, tmr_tc;
  logic [TW-1:0] tmr_val;
  logic          wdata_cap, rdata_cap, addr_inc, addr_clr;

  assign op = op_e'(CMD_OP);

  // Timer starts loaded with the first INIT phase so the reset-release
  // sequence needs no extra load cycle.
  sram_phase_timer #(.W(TW), .RST_VAL(DIV - 1)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_INIT;
      init_lo   <= 1'b0;
      DATA_OUT  <= '0;
      RSP_RDATA <= '0;
      ADDR      <= '0;
    end else begin
      state <= state_nxt;
      if (init_lo_set) init_lo <= 1'b1;
      if (wdata_cap) DATA_OUT <= CMD_WDATA;
      if (rdata_cap) RSP_RDATA <= DATA_IN;
      if (addr_clr) begin
        ADDR <= '0;
      end else if (addr_inc) begin
        ADDR <= ADDR + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    init_lo_set = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = DIV_M1;
    wdata_cap   = 1'b0;
    rdata_cap   = 1'b0;
    addr_inc    = 1'b0;
    addr_clr    = 1'b0;
    CMD_READY   = 1'b0;
    RSP_VALID   = 1'b0;
    COUNTER_CLK = 1'b0;
    COUNTER_RST = 1'b0;
    WE_BAR      = 1'b1;
    DATA_OE     = 1'b0;

    case (state)
      // INIT: counter reset high for DIV cycles, then low for DIV cycles.
      S_INIT: begin
        COUNTER_RST = ~init_lo;
        if (tmr_tc) begin
          if (!init_lo) begin
            init_lo_set = 1'b1;
            tmr_load    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          case (op)
            OP_WRITE: begin
              wdata_cap = 1'b1;
              state_nxt = S_SETUP;
            end
            OP_READ: begin
              tmr_load  = 1'b1;
              tmr_val   = WAIT_M1;
              state_nxt = S_ACCESS;
            end
            OP_CRST: begin
              tmr_load  = 1'b1;
              state_nxt = S_CRST_HI;
            end
            default: state_nxt = S_DONE;
          endcase
        end
      end
      S_SETUP: begin
        DATA_OE   = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = WAIT_M1;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        DATA_OE = 1'b1;
        WE_BAR  = 1'b0;
        if (tmr_tc) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        DATA_OE   = 1'b1;
        tmr_load  = 1'b1;
        state_nxt = S_ADV_HI;
      end
      // Read data is sampled at the end of the access window.
      S_ACCESS: begin
        if (tmr_tc) begin
          rdata_cap = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = S_ADV_HI;
        end
      end
      S_ADV_HI: begin
        COUNTER_CLK = 1'b1;
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          state_nxt = S_ADV_LO;
        end
      end
      // The external counter has stepped on the falling edge entering this
      // state; the shadow follows once the low phase completes.
      S_ADV_LO: begin
        if (tmr_tc) begin
          addr_inc  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_CRST_HI: begin
        COUNTER_RST = 1'b1;
        if (tmr_tc) begin
          addr_clr  = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = S_CRST_LO;
        end
      end
      S_CRST_LO: begin
        if (tmr_tc) state_nxt = S_DONE;
      end
      S_DONE: begin
        RSP_VALID = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: doc/sram_port_sequencer.md
SRAM_PORT_SEQUENCER -- requirements
Module: sram_port_sequencer

Interface
REQ-001 Parameter DIV, default 50, SHALL set clock cycles per COUNTER_CLK/COUNTER_RST phase (minimum 1; 50 gives a 1 MHz external counter clock at 100 MHz).
REQ-002 Parameter WAIT_CYC, default 2, SHALL set SRAM access cycles per read or write strobe (minimum 1).
REQ-003 CLK  in  1  system clock; all state SHALL change on its rising edge.
REQ-004 RST  in  1  reset; asynchronous and active-high.
REQ-005 CMD_VALID  in  1  command offered.
REQ-006 CMD_READY  out  1  command accepted when both CMD_VALID and CMD_READY are high on a rising edge.
REQ-007 CMD_OP  in  2  opcode: 00 write, 01 read, 10 counter reset, 11 no-op.
REQ-008 CMD_WDATA  in  16  write word; upper byte goes to chip 2, lower byte to chip 1.
REQ-009 RSP_VALID  out  1  one-cycle completion pulse.
REQ-010 RSP_RDATA  out  16  last word read.
REQ-011 ADDR  out  12  shadow of the external MC14040B count.
REQ-012 COUNTER_CLK  out  1  external counter clock; the counter advances on the falling edge.
REQ-013 COUNTER_RST  out  1  external counter reset, active-high.
REQ-014 WE_BAR  out  1  SRAM write enable, active-low; CS, OE, BLE and BHE are tied low off-chip.
REQ-015 DATA_OE  out  1  SRAM data bus tristate enable for the top level.
REQ-016 DATA_OUT  out  16  bus drive value.
REQ-017 DATA_IN  in  16  bus sample value.

Function
REQ-018 CMD_READY SHALL be high only in state IDLE.
REQ-019 The FSM SHALL use the states INIT, IDLE, SETUP, STROBE, HOLD, ACCESS, ADV_HI, ADV_LO, CRST_HI, CRST_LO and DONE.
- A write SHALL run IDLE -> SETUP(1 cycle) -> STROBE(WAIT_CYC cycles) -> HOLD(1) -> ADV_HI(DIV) -> ADV_LO(DIV) -> DONE(1) -> IDLE.
REQ-020 Write pin behaviour:
- CMD_WDATA SHALL be latched into DATA_OUT on acceptance.
- DATA_OE SHALL be high in SETUP, STROBE and HOLD.
- WE_BAR SHALL be low only in STROBE.
REQ-021 A read SHALL run IDLE -> ACCESS(WAIT_CYC) -> ADV_HI -> ADV_LO -> DONE, with DATA_OE low and WE_BAR high throughout.
- DATA_IN SHALL be registered into RSP_RDATA on the edge leaving ACCESS.
REQ-022 Counter reset SHALL run IDLE -> CRST_HI(DIV) -> CRST_LO(DIV) -> DONE, with COUNTER_RST high only in CRST_HI; ADDR SHALL clear to 0 on leaving CRST_HI.
REQ-023 COUNTER_CLK SHALL be high only in ADV_HI; ADDR SHALL increment by 1 on leaving ADV_LO and wrap from 4095 to 0.
REQ-024 Opcode 11 SHALL go directly to DONE with no pin activity and no change to ADDR or RSP_RDATA.
REQ-025 RSP_VALID SHALL be high exactly in DONE.
- Latency from the acceptance edge to RSP_VALID SHALL be 3+WAIT_CYC+2*DIV cycles for a write, 1+WAIT_CYC+2*DIV for a read, 1+2*DIV for a counter reset, and 1 for a no-op.
REQ-026 CMD_VALID while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-027 COUNTER_CLK and COUNTER_RST SHALL never be high in the same cycle.
- WE_BAR SHALL never be low while COUNTER_CLK or COUNTER_RST is high.

Reset
REQ-028 While RST is high, outputs SHALL hold:
- WE_BAR=1, DATA_OE=0, COUNTER_CLK=0, COUNTER_RST=1;
- CMD_READY=0, RSP_VALID=0;
- RSP_RDATA=0, DATA_OUT=0, ADDR=0;
- state INIT.
REQ-029 After RST is released, INIT SHALL hold COUNTER_RST high for DIV cycles, then low for DIV cycles, then enter IDLE, with no RSP_VALID pulse.
REQ-030 RST asserted mid-operation SHALL abort the operation immediately; no RSP_VALID SHALL be issued for the aborted command.

Structure
REQ-031 Package sram_seq_pkg SHALL hold the opcode constants, the state encoding and the DIV/WAIT_CYC defaults.
REQ-032 Sub-module sram_phase_timer SHALL be a loadable down-counter with a terminal-count flag, shared by all timed states.

Verification (DIV=2, WAIT_CYC=1)
REQ-033 Release reset -> COUNTER_RST high for 2 cycles then low for 2, CMD_READY rises at cycle 4, ADDR=0.
REQ-034 Write 0xA55A -> DATA_OUT=0xA55A, WE_BAR low for exactly 1 cycle inside DATA_OE high, COUNTER_CLK high for 2 cycles, RSP_VALID at cycle 8, ADDR=1.
REQ-035 Read with DATA_IN=0x3C96 -> RSP_RDATA=0x3C96, RSP_VALID at cycle 6, DATA_OE never high.
REQ-036 4096 consecutive no-op-free reads -> ADDR wraps 4095 to 0; CMD_VALID held high during a busy period accepts no extra command.
REQ-037 RST pulsed during STROBE -> WE_BAR=1 and DATA_OE=0 in the same cycle, no RSP_VALID, INIT sequence repeats.
